// File: rtl/harris_window_generator_if.sv
// Pixel-stream input and 3x3 window output bundle for the Harris window generator.
// master = pixel source / window consumer side, slave = window generator side.
interface harris_window_generator_if #(
  parameter int LUMA_BITS  = 8,
  parameter int COORD_BITS = 10
);
  logic                                in_valid;
  logic                                in_sof;
  logic [LUMA_BITS-1:0]                in_pixel;
  logic [2:0][2:0][LUMA_BITS-1:0]      window;      // window[row][col]
  logic                                advance;
  logic [COORD_BITS-1:0]               centre_x;
  logic [COORD_BITS-1:0]               centre_y;
  logic                                frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  window, advance, centre_x, centre_y, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output window, advance, centre_x, centre_y, frame_done
  );
endinterface

// File: rtl/harris_window_generator.sv
// Raster pixel stream -> sliding 3x3 luma window.
// Two line buffers supply the two lines above the incoming pixel; a 3x3
// register array shifts left one column per accepted pixel. Only windows
// lying fully inside the frame are flagged with advance.
module harris_window_generator #(
  parameter int LUMA_BITS    = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int COORD_BITS   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  harris_window_generator_if.slave  s
);

  localparam int LB_AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMAGE_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMAGE_HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] C_ONE  = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] C_TWO  = COORD_BITS'(2);

  typedef enum logic {ST_WAIT_SOF, ST_RUN} state_t;

  state_t                          r_state, w_state_nxt;
  logic [COORD_BITS-1:0]           r_x, r_y;
  logic [COORD_BITS-1:0]           w_x, w_y;
  logic                            w_accept, w_last, w_interior;
  logic [LB_AW-1:0]                w_lb_addr;
  logic [LUMA_BITS-1:0]            w_lb0_rd, w_lb1_rd;
  logic [LUMA_BITS-1:0]            r_lb0 [IMAGE_WIDTH];  // line y-1
  logic [LUMA_BITS-1:0]            r_lb1 [IMAGE_WIDTH];  // line y-2
  logic [2:0][2:0][LUMA_BITS-1:0]  r_window;
  logic                            r_advance, r_frame_done;
  logic [COORD_BITS-1:0]           r_centre_x, r_centre_y;

  // A pixel is taken when it starts a frame or arrives while a frame is running.
  // An sof pixel always lands at (0,0), even mid-frame.
  assign w_accept   = s.in_valid && (s.in_sof || (r_state == ST_RUN));
  assign w_x        = s.in_sof ? '0 : r_x;
  assign w_y        = s.in_sof ? '0 : r_y;
  assign w_last     = (w_x == X_LAST) && (w_y == Y_LAST);
  assign w_interior = (w_x >= C_TWO) && (w_y >= C_TWO);

  // Combinational line-buffer reads see pre-write contents for this edge.
  assign w_lb_addr = w_x[LB_AW-1:0];
  assign w_lb0_rd  = r_lb0[w_lb_addr];
  assign w_lb1_rd  = r_lb1[w_lb_addr];

  // Frame-state next-state logic: the last pixel of a frame closes it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_last ? ST_WAIT_SOF : ST_RUN;
    end
  end

  // Frame-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WAIT_SOF;
    else        r_state <= w_state_nxt;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_x == X_LAST) begin
        r_x <= '0;
        r_y <= w_y + C_ONE;
      end else begin
        r_x <= w_x + C_ONE;
        r_y <= w_y;
      end
    end
  end

  // Line buffers age by one line per column write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_lb_addr] <= w_lb0_rd;
      r_lb0[w_lb_addr] <= s.in_pixel;
    end
  end

  // Shift the window left and load the new right-hand column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_window[r][0] <= r_window[r][1];
        r_window[r][1] <= r_window[r][2];
      end
      r_window[0][2] <= w_lb1_rd;
      r_window[1][2] <= w_lb0_rd;
      r_window[2][2] <= s.in_pixel;
    end
  end

  // Advance / centre / frame_done, one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_advance    <= 1'b0;
      r_frame_done <= 1'b0;
      r_centre_x   <= '0;
      r_centre_y   <= '0;
    end else begin
      r_advance    <= w_accept && w_interior;
      r_frame_done <= w_accept && w_last;
      if (w_accept && w_interior) begin
        r_centre_x <= w_x - C_ONE;
        r_centre_y <= w_y - C_ONE;
      end
    end
  end

  assign s.window     = r_window;
  assign s.advance    = r_advance;
  assign s.centre_x   = r_centre_x;
  assign s.centre_y   = r_centre_y;
  assign s.frame_done = r_frame_done;

endmodule

// File: doc/harris_window_generator.md
Name: harris_window_generator

Overview:
- Converts a raster pixel stream (x+ right, y+ down) into successive 3x3 luma windows for the Harris matrix stage, which latches a window on every advance pulse.
- Uses two line buffers plus a 3x3 register array. Emits only windows that lie fully inside the image.
- Tracks frame position with column/row counters and a small frame-state FSM.

Parameters:
LUMA_BITS, 8, width of one luma sample
IMAGE_WIDTH, 640, pixels per line (>=3)
IMAGE_HEIGHT, 480, lines per frame (>=3)
COORD_BITS, 10, width of x/y counters and centre coordinates (2^COORD_BITS >= max(IMAGE_WIDTH, IMAGE_HEIGHT))

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel strobe; pixel accepted on any edge with in_valid=1 (no backpressure)
in_sof  input  1  start of frame; qualifies in_valid, marks pixel (0,0)
in_pixel  input  LUMA_BITS  luma sample
window  output  LUMA_BITS x [3][3]  window[row][col]; row 0 = top, col 0 = left
advance  output  1  one-cycle pulse: window holds a new, fully-interior window
centre_x  output  COORD_BITS  x of window[1][1], valid with advance
centre_y  output  COORD_BITS  y of window[1][1], valid with advance
frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, rst_n=0): window all 0, advance=0, centre_x/centre_y=0, frame_done=0, x=y=0, FSM=WAIT_SOF. Line-buffer RAM is not cleared.
- FSM states:
  - WAIT_SOF: pixels without in_sof are dropped. in_valid&in_sof accepts the pixel as (0,0) and goes to RUN.
  - RUN: every accepted pixel advances x. At x=IMAGE_WIDTH-1, x wraps to 0 and y increments. The pixel at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) pulses frame_done next cycle and returns to WAIT_SOF.
- in_sof in RUN (mid-frame): the current frame is abandoned without frame_done. The pixel becomes (0,0) of a new frame, and the state stays RUN.
- Per accepted pixel at (x,y), registered on that edge:
  - Column shift: window[r][0]<=window[r][1]; window[r][1]<=window[r][2].
  - New column: window[0][2]<=lb1[x] (line y-2); window[1][2]<=lb0[x] (line y-1); window[2][2]<=in_pixel.
  - Line buffers: lb1[x]<=lb0[x]; lb0[x]<=in_pixel.
  - Line-buffer reads are of pre-write contents. The read must be combinational or prefetched so the window updates in the same edge.
- advance=1 on the cycle after accepting a pixel with x>=2 and y>=2. On that cycle, centre_x=x-1 and centre_y=y-1.
  - No advance for x<2: windows straddling a line wrap are suppressed.
  - No advance for y<2: stale line-buffer data from a previous frame is never emitted.
- Latency: exactly 1 cycle from accepting pixel to advance. Windows per frame: (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2).
- Idle cycles (in_valid=0): no state change. advance=0, window and centre hold.
- window is stable from an advance until the next accepted pixel. Downstream samples it on the advance cycle.
- in_sof with in_valid=0 is ignored.
- Back-to-back frames: a new in_sof on the cycle frame_done pulses is accepted normally.
- Reset mid-frame: immediate return to reset values. Next frame needs in_sof.
- Widths: counters are COORD_BITS unsigned. No arithmetic on luma.

Test Plan:
- Basic window. IMAGE_WIDTH=4, IMAGE_HEIGHT=4, COORD_BITS=3; pixel=16*y+x, continuous stream from sof.
  - First advance follows pixel (2,2): window rows {0x00,0x01,0x02}, {0x10,0x11,0x12}, {0x20,0x21,0x22}; centre=(1,1).
  - Exactly 4 advances per frame, centres (1,1),(2,1),(1,2),(2,2).
  - frame_done pulses once, the cycle after pixel (3,3).
- Gapped input: same frame with in_valid deasserted on random cycles -> identical window/centre sequence; advance only one cycle after accepted pixels; window holds during gaps.
- Unqualified start: 5 pixels with in_valid=1, in_sof=0 after reset, then the normal frame -> first 5 ignored; output matches the basic window case.
- Mid-frame sof: new in_sof at pixel (1,2) of frame A, new frame B uses value 0x80+16*y+x -> no frame_done for A; no advance until B pixel (2,2); that window's rows 0-1 come from line buffers; only 4 advances from B.
- Async reset: rst_n pulled low between clock edges mid-frame -> window=0, advance=0, frame_done=0 immediately; subsequent pixels dropped until in_sof.
- Consecutive frames: two 4x4 frames, second sof on the frame_done cycle -> 8 advances total with identical centre sequence; second frame windows contain only second-frame values.
